// File: rtl/hls_deadlock_persist_monitor.sv
// Persistent-stall monitor for HLS dataflow regions: flags a deadlock once the
// combined AXIS/child block condition holds for PERSIST_CYCLES consecutive edges.
module hls_deadlock_persist_monitor #(
  parameter int N_AXIS         = 7,
  parameter int N_SUB          = 1,
  parameter int PERSIST_CYCLES = 16,
  parameter int IDX_W          = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_AXIS-1:0] axis_enable,
  input  logic [N_SUB-1:0]  sub_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic              deadlock,
  output logic              deadlock_src,
  output logic [IDX_W-1:0]  deadlock_idx,
  output logic [7:0]        episode_cnt
);

  localparam int CW = $clog2(PERSIST_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERSIST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WATCH,
    DEADLOCK
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              block_q;
  logic              src_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        ep_q;

  logic [N_AXIS-1:0] axis_masked;
  logic              axis_hit;
  logic              raw;
  logic              enter;
  logic [IDX_W-1:0]  axis_idx;
  logic [IDX_W-1:0]  sub_idx;

  assign axis_masked = axis_block_sigs & axis_enable;
  assign axis_hit    = |axis_masked;
  assign raw         = axis_hit | (|sub_block_sigs);

  // Scan downward so the last overwrite leaves the lowest set index.
  always_comb begin
    axis_idx = '0;
    for (int unsigned i = N_AXIS; i > 0; i--) begin
      if (axis_masked[i-1]) axis_idx = IDX_W'(i - 1);
    end
  end

  always_comb begin
    sub_idx = '0;
    for (int unsigned i = N_SUB; i > 0; i--) begin
      if (sub_block_sigs[i-1]) sub_idx = IDX_W'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    enter   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (raw) begin
            if (PERSIST_CYCLES == 1) begin
              state_d = DEADLOCK;
              enter   = 1'b1;
            end else begin
              state_d = WATCH;
              cnt_d   = CW'(1);
            end
          end
        end
        WATCH: begin
          if (!raw) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DEADLOCK;
            cnt_d   = '0;
            enter   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DEADLOCK: state_d = DEADLOCK;
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      block_q <= 1'b0;
      src_q   <= 1'b0;
      idx_q   <= '0;
      ep_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      block_q <= raw;
      if (enter) begin
        src_q <= ~axis_hit;
        idx_q <= axis_hit ? axis_idx : sub_idx;
        if (ep_q != '1) ep_q <= ep_q + 8'd1;
      end
    end
  end

  assign block        = block_q;
  assign deadlock     = (state_q == DEADLOCK);
  assign deadlock_src = src_q;
  assign deadlock_idx = idx_q;
  assign episode_cnt  = ep_q;

endmodule

// File: doc/hls_deadlock_persist_monitor.md
HLS_DEADLOCK_PERSIST_MONITOR -- requirements
Module: hls_deadlock_persist_monitor

Interface
REQ-001 Parameter N_AXIS, default 7: number of AXIS blocking-signal channels; legal range 1..32.
REQ-002 Parameter N_SUB, default 1: number of child-monitor block inputs; legal range 1..16; tie unused bits to 0.
REQ-003 Parameter PERSIST_CYCLES, default 16: consecutive blocked cycles required to declare deadlock; legal range 1..65535.
REQ-004 Parameter IDX_W, default 5: width of the captured channel index; SHALL be at least clog2(max(N_AXIS,N_SUB)), minimum 1.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-007 axis_block_sigs  input  N_AXIS  per-channel AXIS stall indication, bit i = channel i.
REQ-008 axis_enable  input  N_AXIS  runtime mask; a channel is observed only while its bit is 1.
REQ-009 sub_block_sigs  input  N_SUB  block outputs of child monitors.
REQ-010 clear  input  1  synchronous one-cycle pulse that clears the sticky deadlock state.
REQ-011 block  output  1  registered raw-block flag, one-cycle latency.
REQ-012 deadlock  output  1  sticky persistent-deadlock flag.
REQ-013 deadlock_src  output  1  source of the captured channel: 0 = AXIS, 1 = child monitor.
REQ-014 deadlock_idx  output  IDX_W  index of the captured channel.
REQ-015 episode_cnt  output  8  count of deadlock entries, saturating at 255.

Function
REQ-016 Define raw = OR(axis_block_sigs AND axis_enable) OR OR(sub_block_sigs); raw SHALL be purely combinational.
REQ-017 block SHALL equal raw as sampled at the previous rising edge.
REQ-018 The FSM SHALL have states IDLE, WATCH and DEADLOCK, with a persistence counter cnt of width clog2(PERSIST_CYCLES+1).
REQ-019 IDLE: on raw=1, go to DEADLOCK if PERSIST_CYCLES==1; otherwise go to WATCH with cnt<=1. On raw=0, stay in IDLE with cnt=0.
REQ-020 WATCH: raw=0 -> IDLE, cnt<=0.
REQ-021 WATCH: raw=1 with cnt==PERSIST_CYCLES-1 -> DEADLOCK.
REQ-022 WATCH: raw=1 with any other cnt -> cnt<=cnt+1.
REQ-023 DEADLOCK: remain in DEADLOCK regardless of raw until clear=1; on clear go to IDLE with cnt<=0.
REQ-024 A clear in IDLE or WATCH SHALL force IDLE with cnt<=0.
REQ-025 clear has priority over raw on the same edge; raw can re-arm the FSM from the following cycle.
REQ-026 deadlock SHALL be 1 exactly while the state is DEADLOCK; it rises at the edge that samples raw=1 for the PERSIST_CYCLES-th consecutive time.
REQ-027 On each entry into DEADLOCK, if any masked AXIS bit is set: deadlock_src<=0 and deadlock_idx<=lowest set masked AXIS index.
REQ-028 Otherwise on entry: deadlock_src<=1 and deadlock_idx<=lowest set sub_block_sigs index; AXIS channels take priority.
REQ-029 deadlock_src and deadlock_idx SHALL hold their values until the next DEADLOCK entry or reset; clear does not alter them.
REQ-030 episode_cnt SHALL increment by 1 on each entry into DEADLOCK and saturate at 255; clear does not alter it.
REQ-031 A change to axis_enable mid-WATCH takes effect immediately through raw; there is no separate restart.

Reset
REQ-032 While reset=0 (asynchronous): state=IDLE, cnt=0, block=0, deadlock=0, deadlock_src=0, deadlock_idx=0, episode_cnt=0.
REQ-033 A reset asserted mid-WATCH or in DEADLOCK SHALL clear all outputs immediately, without waiting for a clock edge.
REQ-034 After reset deasserts, the first edge SHALL evaluate raw normally; no extra dead cycle is inserted.

Verification
REQ-035 PERSIST_CYCLES=4; axis bit2 high for 4 cycles -> deadlock rises after the 4th edge, deadlock_src=0, deadlock_idx=2, episode_cnt=1.
REQ-036 PERSIST_CYCLES=4; raw high 3 cycles, low 1 cycle, then high 3 cycles -> deadlock stays 0 and block tracks raw with one-cycle delay.
REQ-037 Bits 5 and 1 both high with axis_enable bit1=0 -> deadlock_idx=5; repeat with only sub_block_sigs[0] high -> deadlock_src=1, deadlock_idx=0.
REQ-038 In DEADLOCK, clear pulsed while raw stays high -> deadlock=0 for the following PERSIST_CYCLES edges, then re-enters; episode_cnt=2.
REQ-039 reset driven to 0 between edges while in DEADLOCK -> all outputs 0 before the next edge.
REQ-040 PERSIST_CYCLES=1 with 260 alternating raw/clear episodes -> deadlock rises on the first raw edge each time; episode_cnt saturates at 255.
